// File: rtl/quad_snapshot.sv
// Quadrature snapshot stage: change-detect period timer, armed index capture,
// and a coherent single-edge snapshot of position, delta, period and index.
module quad_snapshot #(
  parameter int CW = 14,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] count,
  input  logic          idx_evt,
  input  logic          arm,
  input  logic          snap_req,
  output logic [CW-1:0] snap_pos,
  output logic [CW-1:0] snap_delta,
  output logic [TW-1:0] snap_period,
  output logic [CW-1:0] snap_idx_pos,
  output logic          snap_idx_hit,
  output logic          snap_valid,
  output logic          armed
);

  localparam logic [TW-1:0] TMAX = '1;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_prev_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] last_period_q, last_period_d;
  logic [CW-1:0] idx_pos_q, idx_pos_d;
  logic          idx_hit_q, idx_hit_d;
  logic [CW-1:0] snap_pos_q, snap_delta_q, snap_idx_pos_q;
  logic [TW-1:0] snap_period_q;
  logic          snap_idx_hit_q, snap_valid_q;
  logic          change;

  assign change = (count != count_prev_q);

  always_comb begin
    tmr_d         = tmr_q;
    last_period_d = last_period_q;
    if (change) begin
      tmr_d         = '0;
      last_period_d = (tmr_q == TMAX) ? TMAX : tmr_q + 1'b1;
    end else if (tmr_q == TMAX) begin
      // Stalled encoder: report the saturated period rather than the stale one.
      last_period_d = TMAX;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_pos_d = idx_pos_q;
    idx_hit_d = idx_hit_q;
    if (arm) begin
      // A fresh arm beats a coincident index event.
      state_d   = ARMED;
      idx_hit_d = 1'b0;
    end else if (state_q == ARMED && idx_evt) begin
      state_d   = IDLE;
      idx_pos_d = count;
      idx_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_prev_q  <= '0;
      tmr_q         <= '0;
      last_period_q <= '0;
      idx_pos_q     <= '0;
      idx_hit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_prev_q  <= count;
      tmr_q         <= tmr_d;
      last_period_q <= last_period_d;
      idx_pos_q     <= idx_pos_d;
      idx_hit_q     <= idx_hit_d;
    end
  end

  // Snapshot samples pre-edge register values so same-edge updates land in the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_pos_q     <= '0;
      snap_delta_q   <= '0;
      snap_period_q  <= '0;
      snap_idx_pos_q <= '0;
      snap_idx_hit_q <= 1'b0;
      snap_valid_q   <= 1'b0;
    end else begin
      snap_valid_q <= snap_req;
      if (snap_req) begin
        snap_pos_q     <= count;
        snap_delta_q   <= count - snap_pos_q;
        snap_period_q  <= last_period_q;
        snap_idx_pos_q <= idx_pos_q;
        snap_idx_hit_q <= idx_hit_q;
      end
    end
  end

  assign snap_pos     = snap_pos_q;
  assign snap_delta   = snap_delta_q;
  assign snap_period  = snap_period_q;
  assign snap_idx_pos = snap_idx_pos_q;
  assign snap_idx_hit = snap_idx_hit_q;
  assign snap_valid   = snap_valid_q;
  assign armed        = (state_q == ARMED);

endmodule

// File: tb/tb_quad_snapshot.sv
// Randomized + directed bench for quad_snapshot against an edge-timestamp reference model.
module tb_quad_snapshot;
  localparam int CW = 14;
  localparam int TW = 16;
  localparam longint TMAX = (1 << TW) - 1;

  logic          clk, rst_n;
  logic [CW-1:0] count;
  logic          idx_evt, arm, snap_req;
  logic [CW-1:0] snap_pos, snap_delta, snap_idx_pos;
  logic [TW-1:0] snap_period;
  logic          snap_idx_hit, snap_valid, armed;

  int n_cmp = 0;
  int n_bad = 0;

  quad_snapshot #(.CW(CW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .count(count), .idx_evt(idx_evt), .arm(arm),
    .snap_req(snap_req), .snap_pos(snap_pos), .snap_delta(snap_delta),
    .snap_period(snap_period), .snap_idx_pos(snap_idx_pos),
    .snap_idx_hit(snap_idx_hit), .snap_valid(snap_valid), .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: period = edges elapsed between count changes, from an edge counter.
  longint        ecnt = 0, last_chg = 0;
  logic [CW-1:0] m_prev, m_ipos, m_spos, m_sdelta, m_sipos;
  logic [TW-1:0] m_per, m_sper;
  logic          m_armed, m_hit, m_shit, m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_chg = ecnt;
      m_prev = '0; m_per = '0; m_armed = 1'b0; m_ipos = '0; m_hit = 1'b0;
      m_spos = '0; m_sdelta = '0; m_sper = '0; m_sipos = '0; m_shit = 1'b0;
      m_valid = 1'b0;
    end else begin
      ecnt++;
      m_valid = snap_req;
      if (snap_req) begin
        m_sdelta = count - m_spos;
        m_spos   = count;
        m_sper   = m_per;
        m_sipos  = m_ipos;
        m_shit   = m_hit;
      end
      if (count != m_prev) begin
        m_per    = TW'((ecnt - last_chg) > TMAX ? TMAX : (ecnt - last_chg));
        last_chg = ecnt;
      end else if (ecnt - 1 - last_chg >= TMAX) begin
        m_per = TW'(TMAX);
      end
      m_prev = count;
      if (arm) begin
        m_armed = 1'b1; m_hit = 1'b0;
      end else if (m_armed && idx_evt) begin
        m_ipos = count; m_hit = 1'b1; m_armed = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock, then compare every output with the model away from the edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("valid", 32'(snap_valid), 32'(m_valid));
    chk("armed", 32'(armed), 32'(m_armed));
    chk("pos", 32'(snap_pos), 32'(m_spos));
    chk("delta", 32'(snap_delta), 32'(m_sdelta));
    chk("period", 32'(snap_period), 32'(m_sper));
    chk("ipos", 32'(snap_idx_pos), 32'(m_sipos));
    chk("ihit", 32'(snap_idx_hit), 32'(m_shit));
  endtask

  task automatic idle_in();
    arm = 1'b0; idx_evt = 1'b0; snap_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; count = '0; idle_in();
    repeat (3) @(negedge clk);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_pos", 32'(snap_pos), 0);
    chk("rst_valid", 32'(snap_valid), 0);
    rst_n = 1'b1;

    // First snapshot after reset, no change seen: period and delta from 0.
    snap_req = 1'b1; step();
    chk("rst_snap_per", 32'(snap_period), 0);
    chk("rst_snap_dlt", 32'(snap_delta), 0);

    count = 14'd100; step();
    chk("s1_valid", 32'(snap_valid), 1);
    chk("s1_pos", 32'(snap_pos), 100);
    chk("s1_delta", 32'(snap_delta), 100);
    snap_req = 1'b0; step();
    chk("s1_pulse", 32'(snap_valid), 0);
    chk("s1_hold", 32'(snap_pos), 100);
    count = 14'd90; snap_req = 1'b1; step();
    chk("s2_delta", 32'(snap_delta), 32'h3FF6);

    count = 14'd16383; step();
    count = 14'd2; step();
    chk("wrap_delta", 32'(snap_delta), 3);
    chk("b2b_valid", 32'(snap_valid), 1);
    snap_req = 1'b0;

    for (int r = 0; r < 6; r++) begin
      count = count + 1'b1;
      repeat (7) step();
    end
    snap_req = 1'b1; step();
    chk("per7", 32'(snap_period), 7);
    snap_req = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    snap_req = 1'b1; step();
    chk("per_sat", 32'(snap_period), 65535);
    snap_req = 1'b0;

    arm = 1'b1; step();
    chk("arm_on", 32'(armed), 1);
    arm = 1'b0; count = 14'd500; idx_evt = 1'b1; step();
    chk("idx_disarm", 32'(armed), 0);
    idx_evt = 1'b0; snap_req = 1'b1; step();
    chk("idx_pos", 32'(snap_idx_pos), 500);
    chk("idx_hit", 32'(snap_idx_hit), 1);
    snap_req = 1'b0; count = 14'd600; idx_evt = 1'b1; step();
    idx_evt = 1'b0; snap_req = 1'b1; step();
    chk("idx_ignored", 32'(snap_idx_pos), 500);
    chk("idx_hit_kept", 32'(snap_idx_hit), 1);

    snap_req = 1'b0; arm = 1'b1; step();
    count = 14'd700; idx_evt = 1'b1; step();
    chk("prio_armed", 32'(armed), 1);
    idle_in(); snap_req = 1'b1; step();
    chk("prio_hit", 32'(snap_idx_hit), 0);
    chk("prio_pos", 32'(snap_idx_pos), 500);

    // Async reset in the middle of the high phase while armed.
    idle_in(); arm = 1'b1; step(); arm = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("ar_armed", 32'(armed), 0);
    chk("ar_pos", 32'(snap_pos), 0);
    chk("ar_ipos", 32'(snap_idx_pos), 0);
    chk("ar_period", 32'(snap_period), 0);
    chk("ar_hit", 32'(snap_idx_hit), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 19) == 0) count = CW'($urandom);
        else count = count + CW'($urandom_range(0, 6)) - CW'(3);
      end
      arm      = ($urandom_range(0, 19) == 0);
      idx_evt  = ($urandom_range(0, 9) == 0);
      snap_req = ($urandom_range(0, 4) == 0);
      if (i == 1500) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
